// File: rtl/mult_div_ctrl.sv
// -----------------------------------------------------------------------------
// mult_div_ctrl
//
// Sequential signed 32x32 multiply / divide unit with HI/LO result registers.
// A multiply uses radix-2 Booth recoding. A divide uses restoring division on
// the operand magnitudes, and the signs are put back in a final FIX step.
// One iteration is performed per clock.
//
// Ports
//   clock     in   rising-edge system clock
//   reset     in   asynchronous active-low reset
//   start     in   request a new operation (sampled only while idle)
//   op        in   0 = signed multiply, 1 = signed divide
//   opA       in   [31:0] multiplicand / dividend
//   opB       in   [31:0] multiplier / divisor
//   busy      out  high while an operation is in progress
//   done      out  one-cycle pulse when hi/lo hold a new result
//   HI_write  out  HI register write strobe, coincident with done
//   LO_write  out  LO register write strobe, coincident with done
//   div_zero  out  one-cycle pulse on a divide-by-zero request
//   hi        out  [31:0] product[63:32] or remainder
//   lo        out  [31:0] product[31:0] or quotient
// -----------------------------------------------------------------------------
module mult_div_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    output logic        busy,
    output logic        done,
    output logic        HI_write,
    output logic        LO_write,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MULT = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      state_q;
    logic [5:0]  cnt_q;
    // Booth: acc_q is the upper partial product (one guard bit), q_q holds the
    // multiplier and receives the low product bits.
    // Divide: acc_q is the partial remainder, q_q shifts the dividend out and
    // the quotient bits in.
    logic [32:0] acc_q;
    logic [31:0] q_q;
    logic        qm1_q;
    logic [31:0] m_q;
    logic        op_q;
    logic        quo_neg_q;
    logic        rem_neg_q;
    logic        dz_pend_q;
    logic        busy_q;
    logic        done_q;
    logic        div_zero_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    // Magnitudes of the raw operands. 0x80000000 maps to 2^31, which is still
    // correct when read as unsigned.
    logic [31:0] abs_a_s;
    logic [31:0] abs_b_s;

    // Operand magnitudes for the divide path
    always_comb begin
        abs_a_s = opA[31] ? (32'd0 - opA) : opA;
        abs_b_s = opB[31] ? (32'd0 - opB) : opB;
    end

    // One Booth step: add or subtract the multiplicand, then arithmetic shift
    logic [32:0] m_ext_s;
    logic [32:0] booth_sum_s;
    logic [32:0] booth_acc_d;
    logic [31:0] booth_q_d;
    logic        booth_qm1_d;

    // Booth recoding of the current multiplier bit pair
    always_comb begin
        m_ext_s = {m_q[31], m_q};
        case ({q_q[0], qm1_q})
            2'b01:   booth_sum_s = acc_q + m_ext_s;
            2'b10:   booth_sum_s = acc_q - m_ext_s;
            default: booth_sum_s = acc_q;
        endcase
        booth_acc_d = {booth_sum_s[32], booth_sum_s[32:1]};
        booth_q_d   = {booth_sum_s[0], q_q[31:1]};
        booth_qm1_d = q_q[0];
    end

    // One restoring-division step on unsigned magnitudes
    logic [32:0] div_shift_s;
    logic [32:0] div_trial_s;
    logic [32:0] div_acc_d;
    logic [31:0] div_q_d;

    // Trial subtraction; a borrow restores the shifted remainder
    always_comb begin
        div_shift_s = {acc_q[31:0], q_q[31]};
        div_trial_s = div_shift_s - {1'b0, m_q};
        if (div_trial_s[32]) begin
            div_acc_d = div_shift_s;
        end else begin
            div_acc_d = div_trial_s;
        end
        div_q_d = {q_q[30:0], ~div_trial_s[32]};
    end

    // Sign fix-up: the quotient is negative when the operand signs differ, and
    // the remainder takes the sign of the dividend
    logic [31:0] fix_hi_s;
    logic [31:0] fix_lo_s;

    // Final result selection for the FIX state
    always_comb begin
        if (op_q) begin
            fix_lo_s = quo_neg_q ? (32'd0 - q_q) : q_q;
            fix_hi_s = rem_neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        end else begin
            fix_lo_s = q_q;
            fix_hi_s = acc_q[31:0];
        end
    end

    // Control FSM, datapath registers and registered outputs.
    // The counter runs 0..32. Iterations happen while it is below 32, and the
    // cycle that sees 32 hands over to FIX. That places done in the cycle after
    // the 34th edge following the start edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 6'd0;
            acc_q      <= 33'd0;
            q_q        <= 32'd0;
            qm1_q      <= 1'b0;
            m_q        <= 32'd0;
            op_q       <= 1'b0;
            quo_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            dz_pend_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
        end else begin
            done_q     <= 1'b0;
            dz_pend_q  <= 1'b0;
            // Divide-by-zero is flagged at the start edge and shown one cycle later
            div_zero_q <= dz_pend_q;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        cnt_q <= 6'd0;
                        acc_q <= 33'd0;
                        qm1_q <= 1'b0;
                        if (!op) begin
                            m_q     <= opA;
                            q_q     <= opB;
                            state_q <= S_MULT;
                            busy_q  <= 1'b1;
                        end else if (opB == 32'd0) begin
                            dz_pend_q <= 1'b1;
                            state_q   <= S_IDLE;
                            busy_q    <= 1'b0;
                        end else begin
                            m_q       <= abs_b_s;
                            q_q       <= abs_a_s;
                            quo_neg_q <= opA[31] ^ opB[31];
                            rem_neg_q <= opA[31];
                            state_q   <= S_DIV;
                            busy_q    <= 1'b1;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_MULT: begin
                    busy_q <= 1'b1;
                    if (cnt_q == 6'd32) begin
                        state_q <= S_FIX;
                    end else begin
                        acc_q <= booth_acc_d;
                        q_q   <= booth_q_d;
                        qm1_q <= booth_qm1_d;
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                S_DIV: begin
                    busy_q <= 1'b1;
                    if (cnt_q == 6'd32) begin
                        state_q <= S_FIX;
                    end else begin
                        acc_q <= div_acc_d;
                        q_q   <= div_q_d;
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                S_FIX: begin
                    hi_q    <= fix_hi_s;
                    lo_q    <= fix_lo_s;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign HI_write = done_q;
    assign LO_write = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult_div_ctrl
//
// Self-checking bench for mult_div_ctrl. Expected results come from plain
// 64-bit signed arithmetic. Expected timing comes from the stated latencies.
// -----------------------------------------------------------------------------
module tb_mult_div_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        op    = 1'b0;
    logic [31:0] opA   = 32'd0;
    logic [31:0] opB   = 32'd0;
    logic        busy, done, HI_write, LO_write, div_zero;
    logic [31:0] hi, lo;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [31:0] last_hi = 32'd0;
    logic [31:0] last_lo = 32'd0;

    mult_div_ctrl dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .opA(opA), .opB(opB), .busy(busy), .done(done),
        .HI_write(HI_write), .LO_write(LO_write), .div_zero(div_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    // Reference: {hi, lo} from ordinary signed 64-bit arithmetic
    function automatic logic [63:0] model(input logic o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, qq, rr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!o) begin
            p = sa * sb;
            return p;
        end else begin
            qq = sa / sb;
            rr = sa % sb;
            return {rr[31:0], qq[31:0]};
        end
    endfunction

    // Issue one operation from posedge+1 and wait for done (bounded).
    // lat = edges after the start edge at which done was observed (-1 on timeout)
    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rh, output logic [31:0] rl,
                          output int lat, output int pulse_ok);
        start = 1'b1; op = o; opA = a; opB = b;
        @(posedge clock); #1;
        start = 1'b0; opA = $urandom; opB = $urandom; op = 1'($urandom_range(0, 1));
        lat = -1; rh = 32'd0; rl = 32'd0; pulse_ok = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clock); #1;
            if (done) begin
                lat = n; rh = hi; rl = lo;
                pulse_ok = (HI_write && LO_write && busy) ? 1 : 0;
                break;
            end
        end
        if (lat > 0) begin
            @(posedge clock); #1;
            if (done || HI_write || LO_write || busy) pulse_ok = 0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        total_cnt++;
        if ({busy, done, HI_write, LO_write, div_zero, hi, lo} !== 69'd0) begin
            $display("FAIL reset_outputs: got busy=%b done=%b hw=%b lw=%b dz=%b hi=%h lo=%h, want all 0",
                     busy, done, HI_write, LO_write, div_zero, hi, lo);
        end else pass_cnt++;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_mult_directed();
        logic [31:0] rh, rl;
        int lat, pok;
        run_op(1'b0, 32'd7, 32'hFFFFFFFD, rh, rl, lat, pok);
        total_cnt++;
        if ({rh, rl} !== 64'hFFFFFFFF_FFFFFFEB) $display("FAIL mult_7xm3: got %h_%h want ffffffff_ffffffeb", rh, rl);
        else pass_cnt++;
        total_cnt++;
        if (lat != 34) $display("FAIL mult_latency: got %0d want 34", lat);
        else pass_cnt++;
        total_cnt++;
        if (pok != 1) $display("FAIL mult_strobes: got pulse_ok=%0d want 1", pok);
        else pass_cnt++;
        run_op(1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, rh, rl, lat, pok);
        total_cnt++;
        if ({rh, rl} !== 64'h3FFFFFFF_00000001) $display("FAIL mult_max: got %h_%h want 3fffffff_00000001", rh, rl);
        else pass_cnt++;
        last_hi = rh; last_lo = rl;
    endtask

    task automatic test_div_directed();
        logic [31:0] rh, rl;
        int lat, pok;
        run_op(1'b1, 32'hFFFFFFF9, 32'd2, rh, rl, lat, pok);
        total_cnt++;
        if ({rh, rl} !== 64'hFFFFFFFF_FFFFFFFD) $display("FAIL div_m7_2: got %h_%h want ffffffff_fffffffd", rh, rl);
        else pass_cnt++;
        total_cnt++;
        if (lat != 34 || pok != 1) $display("FAIL div_timing: got lat=%0d pulse_ok=%0d want 34/1", lat, pok);
        else pass_cnt++;
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, rh, rl, lat, pok);
        total_cnt++;
        if ({rh, rl} !== 64'h00000000_80000000) $display("FAIL div_overflow: got %h_%h want 00000000_80000000", rh, rl);
        else pass_cnt++;
        last_hi = rh; last_lo = rl;
    endtask

    task automatic test_div_zero();
        int dz_cnt, dz_at, bad;
        dz_cnt = 0; dz_at = -1; bad = 0;
        start = 1'b1; op = 1'b1; opA = 32'd5; opB = 32'd0;
        @(posedge clock); #1;
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (div_zero) begin dz_cnt++; dz_at = i; end
            if (done || busy || HI_write || LO_write) bad = 1;
            @(posedge clock); #1;
        end
        total_cnt++;
        if (dz_cnt != 1 || dz_at != 1) $display("FAIL div_zero_pulse: got count=%0d at=%0d want 1 at 1", dz_cnt, dz_at);
        else pass_cnt++;
        total_cnt++;
        if (bad != 0) $display("FAIL div_zero_quiet: got done/busy activity=%0d want 0", bad);
        else pass_cnt++;
        total_cnt++;
        if ({hi, lo} !== {last_hi, last_lo}) $display("FAIL div_zero_hold: got %h_%h want %h_%h", hi, lo, last_hi, last_lo);
        else pass_cnt++;
    endtask

    task automatic test_restart_ignored();
        int n;
        logic [63:0] exp;
        logic [31:0] rh, rl;
        exp = model(1'b0, 32'h00012345, 32'hFFFF0003);
        start = 1'b1; op = 1'b0; opA = 32'h00012345; opB = 32'hFFFF0003;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #1 start = 1'b1; op = 1'b1; opA = 32'h55555555; opB = 32'd3;
        @(posedge clock); #1;
        start = 1'b0; opA = 32'hDEADBEEF;
        n = 6; rh = 32'd0; rl = 32'd0;
        while (!done && n < 60) begin
            @(posedge clock); #1; n++;
        end
        rh = hi; rl = lo;
        total_cnt++;
        if ({rh, rl} !== exp || n != 34) $display("FAIL restart_ignored: got %h_%h at %0d want %h at 34", rh, rl, n, exp);
        else pass_cnt++;
        last_hi = rh; last_lo = rl;
        @(posedge clock); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rh, rl;
        int lat, pok, n;
        logic [63:0] exp;
        run_op(1'b1, 32'd1000, 32'hFFFFFFF9, rh, rl, lat, pok);
        // run_op returns one cycle after the done cycle; redo the timing by hand
        start = 1'b1; op = 1'b0; opA = 32'd9; opB = 32'd11;
        @(posedge clock); #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 60) begin @(posedge clock); #1; n++; end
        // now in the DONE cycle: request a new op and hold it into IDLE
        exp = model(1'b1, 32'hFFFF8000, 32'd77);
        start = 1'b1; op = 1'b1; opA = 32'hFFFF8000; opB = 32'd77;
        @(posedge clock); #1;
        @(posedge clock); #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 60) begin @(posedge clock); #1; n++; end
        total_cnt++;
        if ({hi, lo} !== exp || n != 34) $display("FAIL back_to_back: got %h_%h at %0d want %h at 34", hi, lo, n, exp);
        else pass_cnt++;
        last_hi = hi; last_lo = lo;
        @(posedge clock); #1;
    endtask

    task automatic test_reset_mid_div();
        logic [31:0] rh, rl;
        int lat, pok, bad;
        start = 1'b1; op = 1'b1; opA = 32'd100000; opB = 32'd7;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        total_cnt++;
        if ({busy, done, HI_write, LO_write, div_zero, hi, lo} !== 69'd0)
            $display("FAIL reset_mid_div: got busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo);
        else pass_cnt++;
        bad = 0;
        repeat (3) begin @(posedge clock); #1; if (done || busy) bad = 1; end
        total_cnt++;
        if (bad != 0) $display("FAIL reset_no_done: got activity=%0d want 0", bad);
        else pass_cnt++;
        #2 reset = 1'b1;
        @(posedge clock); #1;
        run_op(1'b0, 32'hFFFFFF00, 32'h00000100, rh, rl, lat, pok);
        total_cnt++;
        if ({rh, rl} !== 64'hFFFFFFFF_FFFF0000 || lat != 34) $display("FAIL mult_after_reset: got %h_%h lat=%0d want ffffffff_ffff0000 lat=34", rh, rl, lat);
        else pass_cnt++;
        last_hi = rh; last_lo = rl;
    endtask

    task automatic test_random();
        logic [31:0] a, b, rh, rl;
        logic o;
        logic [63:0] exp;
        int lat, pok;
        for (int i = 0; i < 40; i++) begin
            o = 1'($urandom_range(0, 1));
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 7))
                0: a = 32'h80000000;
                1: b = 32'hFFFFFFFF;
                2: b = 32'h80000000;
                3: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            if (o && b == 32'd0) b = 32'd1;
            exp = model(o, a, b);
            run_op(o, a, b, rh, rl, lat, pok);
            total_cnt++;
            if ({rh, rl} !== exp) $display("FAIL random_result op=%0d a=%h b=%h: got %h_%h want %h", o, a, b, rh, rl, exp);
            else pass_cnt++;
            total_cnt++;
            if (lat != 34 || pok != 1) $display("FAIL random_timing op=%0d: got lat=%0d pulse_ok=%0d want 34/1", o, lat, pok);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_mult_directed();
        test_div_directed();
        test_div_zero();
        test_restart_ignored();
        test_back_to_back();
        test_reset_mid_div();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
